// File: rtl/stage1_ctrl_pkg.sv
// stage1_pkg: shared types and default sizing for the stage1 sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stage1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } stage1_st_t;

  // 9 weight rows per load; BN config rides the same beats through 9 stages
  localparam int STAGE1_LOAD_CYC = 9;
  // stage1 'in' to 'ReLU_out'
  localparam int STAGE1_PIPE_LAT = 28;
  // datapath word width
  localparam int STAGE1_INT_BITS = 13;
  // vector counter width
  localparam int STAGE1_CNT_W    = 16;

endpackage

// File: rtl/stage1_ctrl_if.sv
// stage1_ctrl_if: job control, load handshake, vector handshake and result
//   qualifiers between the layer scheduler / stage1 datapath and the sequencer.
// Latency: n/a (wires only). Backpressure: w_ready / in_ready from the slave.
// Ports (slave view): in  start, keep_w, num_vec, w_valid, in_valid
//                     out w_ready, weight_en, in_ready, in_gate, out_valid,
//                         out_last, busy, done, zero_word
interface stage1_ctrl_if
  import stage1_pkg::*;
#(
  parameter int int_bits = STAGE1_INT_BITS,
  parameter int CNT_W    = STAGE1_CNT_W
);

  logic                start;
  logic                keep_w;
  logic [CNT_W-1:0]    num_vec;
  logic                w_valid;
  logic                w_ready;
  logic                weight_en;
  logic                in_valid;
  logic                in_ready;
  logic                in_gate;
  logic                out_valid;
  logic                out_last;
  logic                busy;
  logic                done;
  // word the stage1 input mux substitutes on every lane when in_gate is 0
  logic [int_bits-1:0] zero_word;

  modport master (
    output start, keep_w, num_vec, w_valid, in_valid,
    input  w_ready, weight_en, in_ready, in_gate, out_valid, out_last,
           busy, done, zero_word
  );

  modport slave (
    input  start, keep_w, num_vec, w_valid, in_valid,
    output w_ready, weight_en, in_ready, in_gate, out_valid, out_last,
           busy, done, zero_word
  );

endinterface

// File: rtl/stage1_ctrl_valid_delay.sv
// valid_delay: DEPTH-bit shift line marking which datapath slots carry real data.
// Latency: din at cycle t appears on dout at cycle t+DEPTH.
// Backpressure: none; shifts every cycle.
// Ports: clk, reset (async, active-high), din, dout (tail bit), empty (all bits 0)
module valid_delay #(
  parameter int DEPTH = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic empty
);

  logic [DEPTH-1:0] q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= (q << 1) | DEPTH'(din);
    end
  end

  assign dout  = q[DEPTH-1];
  assign empty = ~|q;

endmodule

// File: rtl/stage1_ctrl.sv
// stage1_ctrl: sequences weight/BN load, vector streaming with zero bubbles, and drain.
// Latency: start->busy/first ready 1 cycle; accept->out_valid PIPE_LAT; last out_valid->done 1.
// Backpressure: w_valid / in_valid low stall the load / insert bubbles; readys are registered.
// Ports: clk, reset (async, active-high), ctl (stage1_ctrl_if.slave)
module stage1_ctrl
  import stage1_pkg::*;
#(
  parameter int int_bits = STAGE1_INT_BITS,
  parameter int LOAD_CYC = STAGE1_LOAD_CYC,
  parameter int PIPE_LAT = STAGE1_PIPE_LAT,
  parameter int CNT_W    = STAGE1_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  stage1_ctrl_if.slave ctl
);

  localparam int LD_W = $clog2(LOAD_CYC + 1);

  stage1_st_t       state;
  logic             w_ready_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             done_q;
  logic             out_valid_q;
  logic [LD_W-1:0]  ld_cnt;
  logic [CNT_W-1:0] vec_tot;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] out_cnt;

  logic w_beat;
  logic accept;
  logic line_out;
  logic line_empty;

  // Beats and accepts qualify same-cycle data, so they stay combinational.
  assign w_beat = ctl.w_valid & w_ready_q;
  assign accept = ctl.in_valid & in_ready_q;

  // The first PIPE_LAT-1 stages live in valid_delay and the last one is
  // out_valid_q. When the final result is on out_valid, the line behind it is
  // already empty, so DRAIN can hand over to DONE on that same cycle and done
  // lands exactly one cycle after the last out_valid.
  valid_delay #(
    .DEPTH (PIPE_LAT - 1)
  ) u_valid_delay (
    .clk   (clk),
    .reset (reset),
    .din   (accept),
    .dout  (line_out),
    .empty (line_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= line_out;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      w_ready_q  <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ld_cnt     <= '0;
      vec_tot    <= '0;
      acc_cnt    <= '0;
      out_cnt    <= '0;
    end else begin
      done_q <= 1'b0;
      if (out_valid_q) begin
        out_cnt <= out_cnt + CNT_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (ctl.start) begin
            vec_tot <= ctl.num_vec;
            ld_cnt  <= '0;
            acc_cnt <= '0;
            out_cnt <= '0;
            busy_q  <= 1'b1;
            if (!ctl.keep_w) begin
              state     <= ST_LOAD;
              w_ready_q <= 1'b1;
            end else if (ctl.num_vec == '0) begin
              // empty job: never open in_ready
              state <= ST_DRAIN;
            end else begin
              state      <= ST_STREAM;
              in_ready_q <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          if (w_beat) begin
            ld_cnt <= ld_cnt + LD_W'(1);
            if (ld_cnt == LD_W'(LOAD_CYC - 1)) begin
              w_ready_q <= 1'b0;
              if (vec_tot == '0) begin
                state <= ST_DRAIN;
              end else begin
                state      <= ST_STREAM;
                in_ready_q <= 1'b1;
              end
            end
          end
        end

        ST_STREAM: begin
          if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
            if (acc_cnt + CNT_W'(1) == vec_tot) begin
              state      <= ST_DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end

        ST_DRAIN: begin
          if (line_empty) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end
        end

        ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end

        default: begin
          state      <= ST_IDLE;
          w_ready_q  <= 1'b0;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign ctl.w_ready   = w_ready_q;
  assign ctl.weight_en = w_beat;
  assign ctl.in_ready  = in_ready_q;
  assign ctl.in_gate   = accept;
  assign ctl.out_valid = out_valid_q;
  assign ctl.out_last  = out_valid_q & (out_cnt == vec_tot - CNT_W'(1));
  assign ctl.busy      = busy_q;
  assign ctl.done      = done_q;
  assign ctl.zero_word = {int_bits{1'b0}};

endmodule
